// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed seven-segment scanner: steps one digit per clk_1khz rising edge,
// inserting a dead-time gap before each digit and showing a frame-coherent snapshot.
module display_scan_4dig #(
  parameter int BLANK_CYC    = 120,
  parameter int COMMON_ANODE = 1
) (
  input  logic        clk_12mhz,
  input  logic        rst_n,
  input  logic        clk_1khz,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = 10;
  localparam logic [CW-1:0] LOAD = (BLANK_CYC == 0) ? '0 : CW'(BLANK_CYC - 1);
  localparam bit ACT_LOW = (COMMON_ANODE != 0);

  typedef enum logic [1:0] {WAIT, BLANK, DRIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx;
  logic            sync1, sync2, hist;
  logic            scan_tick;
  logic [15:0]     snap_digits;
  logic [3:0]      snap_dp;
  logic            snap_lz;
  logic [3:0]      nib;
  logic [6:0]      seg_raw;
  logic [3:0]      lz_blank;
  logic [3:0]      an_h;
  logic [6:0]      seg_h;
  logic            dp_h;

  // clk_1khz is asynchronous data; only its synchronised rising edge matters
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= clk_1khz;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign scan_tick = sync2 & ~hist;

  // The snapshot is taken as idx wraps, so a whole frame shows one set of inputs
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 2'd3;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      state       <= WAIT;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (scan_tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_digits <= digits;
          snap_dp     <= dp_en;
          snap_lz     <= blank_lz;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT, DRIVE: begin
        if (scan_tick) begin
          if (BLANK_CYC == 0) begin
            state_nxt = DRIVE;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = LOAD;
          end
        end
      end
      BLANK: begin
        if (scan_tick) begin
          cnt_nxt = LOAD;
        end else if (cnt == '0) begin
          state_nxt = DRIVE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Segment patterns are active-high here, bit 0 = a; polarity is applied at the output flops
  always_comb begin
    nib = snap_digits[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: seg_raw = 7'h3F;
      4'h1: seg_raw = 7'h06;
      4'h2: seg_raw = 7'h5B;
      4'h3: seg_raw = 7'h4F;
      4'h4: seg_raw = 7'h66;
      4'h5: seg_raw = 7'h6D;
      4'h6: seg_raw = 7'h7D;
      4'h7: seg_raw = 7'h07;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h6F;
      4'hA: seg_raw = 7'h77;
      4'hB: seg_raw = 7'h7C;
      4'hC: seg_raw = 7'h39;
      4'hD: seg_raw = 7'h5E;
      4'hE: seg_raw = 7'h79;
      default: seg_raw = 7'h71;
    endcase
  end

  always_comb begin
    lz_blank[3] = (snap_digits[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (snap_digits[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (snap_digits[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
  end

  always_comb begin
    an_h  = 4'b0000;
    seg_h = 7'h00;
    dp_h  = 1'b0;
    if (state == DRIVE) begin
      an_h  = 4'b0001 << idx;
      seg_h = (snap_lz && lz_blank[idx]) ? 7'h00 : seg_raw;
      dp_h  = snap_dp[idx];
    end
  end

  // Registered outputs; an is one-hot or empty by construction, so digits never overlap
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      an  <= ACT_LOW ? 4'hF : 4'h0;
      seg <= ACT_LOW ? 7'h7F : 7'h00;
      dp  <= ACT_LOW;
    end else begin
      an  <= ACT_LOW ? ~an_h : an_h;
      seg <= ACT_LOW ? ~seg_h : seg_h;
      dp  <= ACT_LOW ? ~dp_h : dp_h;
    end
  end

endmodule
